// File: rtl/act_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : act_pkg
//  Description : Shared definitions for the piecewise-linear activation unit.
//                Mode encodings carried with each beat, plus fixed-point
//                ONE/TWO constant helpers derived from the fractional width.
//  Revision    : 1.0  initial release
// ============================================================================
package act_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_HSIG   = 2'd2,
        ACT_HTANH  = 2'd3
    } act_mode_e;

    // 1.0 in the Qx.FRACT_WIDTH format
    function automatic int act_one(input int fract_width);
        return 1 << fract_width;
    endfunction

    // 2.0 in the Qx.FRACT_WIDTH format
    function automatic int act_two(input int fract_width);
        return 2 << fract_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/act_lane.sv
`default_nettype none
// ============================================================================
//  Module      : act_lane
//  Description : Combinational single-lane activation. Maps a signed
//                fixed-point sample and a mode to the activated sample and
//                a clamp flag.
//    x    in  DATA_WIDTH  signed input sample
//    mode in  2           activation select (act_mode_e encoding)
//    y    out DATA_WIDTH  activated sample
//    sat  out 1           input lay strictly beyond the clamp threshold
//  Revision    : 1.0  initial release
// ============================================================================
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  sat
);

    // Thresholds held one bit wider than the sample so that TWO always fits
    // and comparisons against the most-negative input cannot wrap.
    localparam logic signed [DATA_WIDTH:0] c_one     = (DATA_WIDTH+1)'(act_one(FRACT_WIDTH));
    localparam logic signed [DATA_WIDTH:0] c_two     = (DATA_WIDTH+1)'(act_two(FRACT_WIDTH));
    localparam logic signed [DATA_WIDTH:0] c_neg_one = -c_one;
    localparam logic signed [DATA_WIDTH:0] c_neg_two = -c_two;
    // (X + TWO) >>> 2 == (X >>> 2) + TWO/4 because TWO is a multiple of 4;
    // this form keeps the linear segment in DATA_WIDTH bits.
    localparam logic signed [DATA_WIDTH-1:0] c_bias  = (DATA_WIDTH)'(act_two(FRACT_WIDTH) >>> 2);

    logic signed [DATA_WIDTH:0]   w_xe;
    logic signed [DATA_WIDTH-1:0] w_xs;
    logic signed [DATA_WIDTH-1:0] w_quarter;

    assign w_xe      = {x[DATA_WIDTH-1], x};
    assign w_xs      = x;
    assign w_quarter = w_xs >>> 2;

    always_comb begin
        y   = x;
        sat = 1'b0;
        case (mode)
            ACT_RELU: begin
                if (x[DATA_WIDTH-1]) y = '0;
            end
            ACT_HSIG: begin
                if (w_xe <= c_neg_two)   y = '0;
                else if (w_xe >= c_two)  y = c_one[DATA_WIDTH-1:0];
                else                     y = w_quarter + c_bias;
                sat = (w_xe < c_neg_two) | (w_xe > c_two);
            end
            ACT_HTANH: begin
                if (w_xe <= c_neg_one)   y = c_neg_one[DATA_WIDTH-1:0];
                else if (w_xe >= c_one)  y = c_one[DATA_WIDTH-1:0];
                sat = (w_xe < c_neg_one) | (w_xe > c_one);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/act_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : act_unit_pipe
//  Description : Multi-lane two-stage pipelined activation unit with
//                valid/ready streaming and a saturating clamp-beat counter.
//    clk, rst            clock, synchronous active-high reset
//    in_valid/in_ready   input handshake; in_data packs LANES samples,
//                        in_mode travels with the beat
//    out_valid/out_ready output handshake; out_data same packing,
//                        out_sat per-lane clamp flags
//    sat_clr, sat_cnt    clear / count of output beats with any clamp
//  Revision    : 1.0  initial release
// ============================================================================
module act_unit_pipe
    import act_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int LANES       = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic [1:0]                  in_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_sat,
    input  logic                        sat_clr,
    output logic [CNT_WIDTH-1:0]        sat_cnt
);

    logic                        r_s1_valid;
    logic [LANES*DATA_WIDTH-1:0] r_s1_data;
    logic [1:0]                  r_s1_mode;
    logic                        r_s2_valid;
    logic [LANES*DATA_WIDTH-1:0] r_out_data;
    logic [LANES-1:0]            r_out_sat;
    logic [CNT_WIDTH-1:0]        r_sat_cnt;

    logic [LANES*DATA_WIDTH-1:0] w_y;
    logic [LANES-1:0]            w_sat;
    logic                        w_s2_en;
    logic                        w_s1_en;
    logic                        w_sat_inc;

    // Each stage may load when empty or when the stage after it is moving.
    assign w_s2_en  = !r_s2_valid | out_ready;
    assign w_s1_en  = !r_s1_valid | w_s2_en;
    assign in_ready = w_s1_en;

    assign w_sat_inc = r_s2_valid & out_ready & (|r_out_sat)
                     & (r_sat_cnt != {CNT_WIDTH{1'b1}});

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lanes
            act_lane #(
                .DATA_WIDTH  (DATA_WIDTH),
                .FRACT_WIDTH (FRACT_WIDTH)
            ) u_lane (
                .x    (r_s1_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .mode (r_s1_mode),
                .y    (w_y[g*DATA_WIDTH +: DATA_WIDTH]),
                .sat  (w_sat[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= ACT_BYPASS;
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= '0;
            r_sat_cnt  <= '0;
        end else begin
            if (w_s1_en) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data <= in_data;
                    r_s1_mode <= in_mode;
                end
            end
            // Output registers only change when a new beat moves in, so they
            // hold steady under back-pressure.
            if (w_s2_en) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_y;
                    r_out_sat  <= w_sat;
                end
            end
            // Clear takes priority over a coincident increment.
            if (sat_clr)        r_sat_cnt <= '0;
            else if (w_sat_inc) r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign sat_cnt   = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_act_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_act_unit_pipe
//  Description : Self-checking bench for act_unit_pipe (4 lanes, Q7.8).
//                Directed corner beats, a randomized stream with random
//                back-pressure, counter saturation/clear and mid-stream reset,
//                all against an arithmetic reference model and scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_act_unit_pipe;

    localparam int ONE  = 256;
    localparam int TWO  = 512;
    localparam int CMAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_sat;
    logic        sat_clr;
    logic [3:0]  sat_cnt;

    act_unit_pipe #(
        .DATA_WIDTH  (16),
        .FRACT_WIDTH (8),
        .LANES       (4),
        .CNT_WIDTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  sat;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          m_cnt    = 0;
    logic        obs_ov;
    logic [63:0] obs_data;
    logic [3:0]  obs_sat;
    logic        acc;
    logic [63:0] hold_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference activation computed on plain integers.
    function automatic exp_t model(input logic [63:0] d, input logic [1:0] m);
        exp_t r;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] raw;
            int x, y;
            bit s;
            raw = d[k*16 +: 16];
            x = int'($signed(raw));
            y = x;
            s = 0;
            case (m)
                2'd1: y = (x < 0) ? 0 : x;
                2'd2: begin
                    if (x <= -TWO)     y = 0;
                    else if (x >= TWO) y = ONE;
                    else               y = (x + TWO) / 4;
                    s = (x < -TWO) || (x > TWO);
                end
                2'd3: begin
                    if (x <= -ONE)     y = -ONE;
                    else if (x >= ONE) y = ONE;
                    s = (x < -ONE) || (x > ONE);
                end
                default: y = x;
            endcase
            r.data[k*16 +: 16] = y[15:0];
            r.sat[k] = s;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_lane();
        logic [15:0] edges[6];
        edges = '{16'h0100, 16'hFF00, 16'h0200, 16'hFE00, 16'h8000, 16'h7FFF};
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'(int'($urandom_range(0, 1200)) - 600);
            2:       return edges[$urandom_range(0, 5)];
            default: return 16'(int'($urandom_range(0, 600)) - 300);
        endcase
    endfunction

    function automatic logic [63:0] rand_beat();
        return {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
    endfunction

    // One clock cycle: drive, observe at negedge, score, advance past posedge.
    task automatic cyc(input logic iv, input logic [63:0] d, input logic [1:0] m,
                       input logic ordy, input logic clr);
        exp_t e;
        logic exp_ready;
        logic xfer_sat;
        in_valid  = iv;
        in_data   = d;
        in_mode   = m;
        out_ready = ordy;
        sat_clr   = clr;
        xfer_sat  = 1'b0;
        @(negedge clk);
        obs_ov   = out_valid;
        obs_data = out_data;
        obs_sat  = out_sat;
        exp_ready = !(q.size() == 2 && !ordy);
        chk("in_ready", in_ready, exp_ready);
        if (q.size() == 0) chk("out_valid_empty", out_valid, 1'b0);
        if (q.size() == 2) chk("out_valid_full", out_valid, 1'b1);
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_sat", out_sat, e.sat);
                xfer_sat = |e.sat;
            end
        end
        if (clr)                          m_cnt = 0;
        else if (xfer_sat && m_cnt < CMAX) m_cnt++;
        acc = iv && exp_ready;
        if (acc) q.push_back(model(d, m));
        @(posedge clk);
        #1;
        chk("sat_cnt", sat_cnt, m_cnt);
    endtask

    // Single beat with spec-given expected result and 2-cycle latency.
    task automatic directed(input string tag, input logic [63:0] d, input logic [1:0] m,
                            input logic [63:0] expd, input logic [3:0] exps);
        cyc(1'b1, d, m, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b0);
        chk({tag, "_lat1"}, obs_ov, 1'b0);
        cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b0);
        chk({tag, "_lat2"}, obs_ov, 1'b1);
        chk({tag, "_data"}, obs_data, expd);
        chk({tag, "_sat"}, obs_sat, exps);
    endtask

    initial begin
        int idx;
        int budget;
        logic [63:0] cur;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0;
        out_ready = 1'b0; sat_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_sat", out_sat, 4'h0);
        chk("rst_sat_cnt", sat_cnt, 4'h0);
        chk("rst_in_ready", in_ready, 1'b1);

        directed("t1_hsig", 64'h0300_FF00_0100_0000, 2'd2, 64'h0100_0040_00C0_0080, 4'b1000);
        chk("t1_sat_cnt", sat_cnt, 4'd1);
        directed("t2_hsig", 64'h7FFF_8000_FE00_0200, 2'd2, 64'h0100_0000_0000_0100, 4'b1100);
        directed("t3_htanh", 64'h7000_0100_0080_FE00, 2'd3, 64'h0100_0100_0080_FF00, 4'b1001);
        directed("t3_relu", 64'hFF80_0100_8000_0005, 2'd1, 64'h0000_0100_0000_0005, 4'b0000);
        directed("t3_bypass", 64'h1234_8000_7FFF_FF80, 2'd0, 64'h1234_8000_7FFF_FF80, 4'b0000);

        // Randomized stream with alternating modes and random back-pressure.
        idx = 0;
        budget = 0;
        cur = rand_beat();
        while (idx < 12 && budget < 400) begin
            cyc($urandom_range(0, 3) != 0, cur, 2'(idx % 4), 1'($urandom_range(0, 1)), 1'b0);
            if (acc) begin
                idx++;
                cur = rand_beat();
            end
            budget++;
        end
        chk("stream_accepted", idx, 12);
        repeat (4) cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b0);
        chk("stream_drained", q.size(), 0);

        // Back-pressure: two beats loaded, output stalled.
        cyc(1'b1, 64'h0010_0020_0030_0040, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 64'h0300_0000_0000_0000, 2'd2, 1'b0, 1'b0);
        cyc(1'b1, 64'h1111_1111_1111_1111, 2'd0, 1'b0, 1'b0);
        hold_data = obs_data;
        chk("hold_in_ready", in_ready, 1'b0);
        cyc(1'b0, 64'h0, 2'd0, 1'b0, 1'b0);
        chk("hold_stable", obs_data, hold_data);
        cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b0);
        chk("drain_first", obs_ov, 1'b1);
        cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b0);
        chk("drain_second", obs_ov, 1'b1);
        repeat (2) cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b0);

        // Counter saturation, then clear.
        repeat (20) cyc(1'b1, 64'h0300_0300_0300_0300, 2'd2, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b0);
        chk("cnt_saturated", sat_cnt, 4'd15);
        cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b1);
        chk("cnt_cleared", sat_cnt, 4'd0);
        cyc(1'b1, 64'hFC00_0000_0000_0000, 2'd3, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b0);
        chk("cnt_one", sat_cnt, 4'd1);
        // Clear coincident with a clamped output transfer.
        cyc(1'b1, 64'hFC00_0000_0000_0000, 2'd3, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b1);
        chk("clr_wins_ov", obs_ov, 1'b1);
        chk("clr_wins", sat_cnt, 4'd0);

        // Reset with two beats in flight.
        cyc(1'b1, 64'h0300_0000_0000_0000, 2'd2, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 64'h0300_0000_0000_0001, 2'd2, 1'b0, 1'b0);
        cyc(1'b1, 64'h0300_0000_0000_0002, 2'd2, 1'b0, 1'b0);
        chk("pre_rst_cnt", sat_cnt, 4'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_cnt = 0;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_sat_cnt", sat_cnt, 4'd0);
        repeat (3) cyc(1'b0, 64'h0, 2'd0, 1'b1, 1'b0);
        directed("post_rst", 64'h0000_0000_0000_0100, 2'd3, 64'h0000_0000_0000_0100, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
